// File: rtl/lock_sequencer_if.sv
`timescale 1ns/1ps
// Request, timer and actuator signals of the canal lock sequencer.
// The lock controller uses the slave modport; the environment uses master.
interface lock_sequencer_if;
   logic       req_up;
   logic       req_down;
   logic       timer_done;
   logic       timer_start;
   logic [9:0] timer_seconds;
   logic       gate_lo_open;
   logic       gate_hi_open;
   logic       fill_valve;
   logic       drain_valve;
   logic       level_high;
   logic       trip_done;
   logic [2:0] state_code;

   modport master (
      output req_up, req_down, timer_done,
      input  timer_start, timer_seconds, gate_lo_open, gate_hi_open,
             fill_valve, drain_valve, level_high, trip_done, state_code
   );

   modport slave (
      input  req_up, req_down, timer_done,
      output timer_start, timer_seconds, gate_lo_open, gate_hi_open,
             fill_valve, drain_valve, level_high, trip_done, state_code
   );
endinterface

// File: rtl/lock_sequencer.sv
`timescale 1ns/1ps
// Two-level canal lock sequencer: latches vessel requests, steps gates and
// valves through timed phases and drives the countdown timer.
module lock_sequencer #(
   parameter logic [9:0] FILL_SECONDS  = 10'd7,
   parameter logic [9:0] DRAIN_SECONDS = 10'd7,
   parameter logic [9:0] GATE_SECONDS  = 10'd5
) (
   input logic             clk,
   input logic             reset,
   lock_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ENTER = 3'd2,
      ST_MOVE  = 3'd3,
      ST_EXIT  = 3'd4,
      ST_REPOS = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic       init_pend_q, init_pend_d;
   logic       pending_up_q, pending_up_d;
   logic       pending_down_q, pending_down_d;
   logic       level_q, level_d;
   logic       timer_start_q, timer_start_d;
   logic [9:0] seconds_q, seconds_d;
   logic       gate_lo_q, gate_lo_d;
   logic       gate_hi_q, gate_hi_d;
   logic       fill_q, fill_d;
   logic       drain_q, drain_d;
   logic       trip_q, trip_d;
   logic       clr_up, clr_down;
   logic       expired;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ST_INIT;
         init_pend_q    <= 1'b1;
         pending_up_q   <= 1'b0;
         pending_down_q <= 1'b0;
         level_q        <= 1'b0;
         timer_start_q  <= 1'b0;
         seconds_q      <= DRAIN_SECONDS;
         gate_lo_q      <= 1'b0;
         gate_hi_q      <= 1'b0;
         fill_q         <= 1'b0;
         drain_q        <= 1'b0;
         trip_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         init_pend_q    <= init_pend_d;
         pending_up_q   <= pending_up_d;
         pending_down_q <= pending_down_d;
         level_q        <= level_d;
         timer_start_q  <= timer_start_d;
         seconds_q      <= seconds_d;
         gate_lo_q      <= gate_lo_d;
         gate_hi_q      <= gate_hi_d;
         fill_q         <= fill_d;
         drain_q        <= drain_d;
         trip_q         <= trip_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_pend_d = 1'b0;
      level_d     = level_q;
      trip_d      = 1'b0;
      clr_up      = 1'b0;
      clr_down    = 1'b0;
      // timer_start_q marks the first cycle of a timed state, where done is stale
      expired     = !timer_start_q && bus.timer_done;

      if (init_pend_q) begin
         state_d = ST_INIT;
      end else begin
         unique case (state_q)
            ST_INIT:  if (expired) begin
                         state_d = ST_IDLE;
                         level_d = 1'b0;
                      end
            ST_IDLE:  if (level_q ? pending_down_q : pending_up_q) begin
                         state_d  = ST_ENTER;
                         clr_up   = !level_q;
                         clr_down = level_q;
                      end else if (level_q ? pending_up_q : pending_down_q) begin
                         state_d = ST_REPOS;
                      end
            ST_ENTER: if (expired) state_d = ST_MOVE;
            ST_MOVE:  if (expired) begin
                         state_d = ST_EXIT;
                         level_d = !level_q;
                      end
            ST_EXIT:  if (expired) begin
                         state_d = ST_IDLE;
                         trip_d  = 1'b1;
                      end
            ST_REPOS: if (expired) begin
                         state_d = ST_IDLE;
                         level_d = !level_q;
                      end
            default:  begin
                         state_d     = ST_INIT;
                         init_pend_d = 1'b1;
                      end
         endcase
      end

      pending_up_d   = (pending_up_q   | bus.req_up)   & ~clr_up;
      pending_down_d = (pending_down_q | bus.req_down) & ~clr_down;
      timer_start_d  = init_pend_q || (state_d != state_q && state_d != ST_IDLE);

      // Actuators follow the next state so they are valid in its first cycle
      seconds_d = seconds_q;
      gate_lo_d = 1'b0;
      gate_hi_d = 1'b0;
      fill_d    = 1'b0;
      drain_d   = 1'b0;
      unique case (state_d)
         ST_INIT: begin
            drain_d   = 1'b1;
            seconds_d = DRAIN_SECONDS;
         end
         ST_ENTER, ST_EXIT: begin
            gate_lo_d = !level_d;
            gate_hi_d = level_d;
            seconds_d = GATE_SECONDS;
         end
         ST_MOVE, ST_REPOS: begin
            fill_d    = !level_d;
            drain_d   = level_d;
            seconds_d = level_d ? DRAIN_SECONDS : FILL_SECONDS;
         end
         default: ;
      endcase
   end

   assign bus.timer_start   = timer_start_q;
   assign bus.timer_seconds = seconds_q;
   assign bus.gate_lo_open  = gate_lo_q;
   assign bus.gate_hi_open  = gate_hi_q;
   assign bus.fill_valve    = fill_q;
   assign bus.drain_valve   = drain_q;
   assign bus.level_high    = level_q;
   assign bus.trip_done     = trip_q;
   assign bus.state_code    = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
`timescale 1ns/1ps
// Bench for lock_sequencer: phase-level model checked every cycle, directed
// scenarios with literal expectations, and a zero-duration instance.
module tb_lock_sequencer;

   localparam logic [9:0] FILL  = 10'd7;
   localparam logic [9:0] DRAIN = 10'd7;
   localparam logic [9:0] GATE  = 10'd5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lock_sequencer_if bus ();
   lock_sequencer_if zbus ();

   lock_sequencer #(.FILL_SECONDS(FILL), .DRAIN_SECONDS(DRAIN), .GATE_SECONDS(GATE))
      u_dut (.clk(clk), .reset(reset), .bus(bus));

   lock_sequencer #(.FILL_SECONDS(10'd0), .DRAIN_SECONDS(10'd0), .GATE_SECONDS(10'd0))
      u_zero (.clk(clk), .reset(reset), .bus(zbus));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_q(input string nm, input int got[$], input int exp[$]);
      check({nm, "_len"}, got.size(), exp.size());
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         check(nm, got[i], exp[i]);
   endtask

   // Timer: done is (count == 0); a start loads a count of 3, so done rises 4 cycles after start.
   int unsigned tcnt = 0;
   always @(posedge clk) begin
      if (bus.timer_start) tcnt <= 3;
      else if (tcnt != 0)  tcnt <= tcnt - 1;
   end
   assign bus.timer_done  = (tcnt == 0);
   assign zbus.timer_done = 1'b1;

   logic rst_at_edge = 1'b0;
   always @(posedge clk) rst_at_edge <= reset;

   // Phase-level model: phase, cycles spent in it, level, pending requests.
   bit        m_on = 0, m_rst, m_lvl, m_pu, m_pd, m_trip;
   int        m_ph, m_age;
   logic [9:0] m_sec;

   function automatic logic [9:0] phase_secs(input int ph, input bit lvl);
      case (ph)
         2, 4:    return GATE;
         3, 5:    return lvl ? DRAIN : FILL;
         default: return DRAIN;
      endcase
   endfunction

   always @(posedge clk) begin
      bit leave, cu, cd, mine, other;
      int nph;
      cu = 0; cd = 0;
      if (!reset) begin
         m_on = 1; m_rst = 1; m_ph = 0; m_age = 0; m_lvl = 0;
         m_pu = 0; m_pd = 0; m_trip = 0; m_sec = DRAIN;
      end else if (m_on) begin
         m_trip = 0;
         if (m_rst) begin
            m_rst = 0;
         end else begin
            nph   = m_ph;
            leave = (m_age >= 1) && bus.timer_done;
            mine  = m_lvl ? m_pd : m_pu;
            other = m_lvl ? m_pu : m_pd;
            case (m_ph)
               0: if (leave) nph = 1;
               1: if (mine) begin nph = 2; cu = !m_lvl; cd = m_lvl; end
                  else if (other) nph = 5;
               2: if (leave) nph = 3;
               3: if (leave) begin nph = 4; m_lvl = !m_lvl; end
               4: if (leave) begin nph = 1; m_trip = 1; end
               5: if (leave) begin nph = 1; m_lvl = !m_lvl; end
               default: nph = 0;
            endcase
            m_age = (nph == m_ph) ? m_age + 1 : 0;
            m_ph  = nph;
            if (m_ph != 1 && m_age == 0) m_sec = phase_secs(m_ph, m_lvl);
         end
         m_pu = (m_pu | bus.req_up)   & !cu;
         m_pd = (m_pd | bus.req_down) & !cd;
      end
   end

   // Compare process: every cycle once the model has seen reset.
   always @(negedge clk) begin
      bit timed, e_start;
      int e_gates, e_valves;
      if (m_on) begin
         timed    = (m_ph != 1) && !m_rst;
         e_start  = timed && (m_age == 0);
         e_gates  = ((m_ph == 2 || m_ph == 4) && !m_rst) ? (m_lvl ? 1 : 2) : 0;
         e_valves = (m_ph == 3 || m_ph == 5) ? (m_lvl ? 1 : 2)
                  : ((m_ph == 0 && !m_rst) ? 1 : 0);
         check("state_code",    int'(bus.state_code), m_ph);
         check("level_high",    int'(bus.level_high), int'(m_lvl));
         check("timer_start",   int'(bus.timer_start), int'(e_start));
         check("timer_seconds", int'(bus.timer_seconds), int'(m_sec));
         check("gates{lo,hi}",  int'({bus.gate_lo_open, bus.gate_hi_open}), e_gates);
         check("valves{fill,drain}", int'({bus.fill_valve, bus.drain_valve}), e_valves);
         check("trip_done",     int'(bus.trip_done), int'(m_trip));
      end
   end

   function automatic int bad_combo(input logic lo, input logic hi, input logic f,
                                    input logic d, input logic [2:0] sc);
      return int'((lo & hi) | ((lo | hi) & (f | d)) | (f & d) |
                  ((sc == 3'd1) & (lo | hi | f | d)));
   endfunction

   // Invariants on both instances and 2-cycle phase length on the zero-duration one.
   int zlen = 0, zcount = 0;
   logic [2:0] zprev = 3'd0;
   always @(negedge clk) begin
      if (m_on) begin
         check("main_invariant", bad_combo(bus.gate_lo_open, bus.gate_hi_open,
               bus.fill_valve, bus.drain_valve, bus.state_code), 0);
         check("zero_invariant", bad_combo(zbus.gate_lo_open, zbus.gate_hi_open,
               zbus.fill_valve, zbus.drain_valve, zbus.state_code), 0);
      end
      if (!rst_at_edge) begin
         zlen = 0;
      end else if (zbus.timer_start || zbus.state_code != zprev) begin
         if (zlen > 0) begin
            check("zero_phase_len", zlen, 2);
            zcount++;
         end
         zlen = zbus.timer_start ? 1 : 0;
      end else if (zlen > 0) begin
         zlen++;
      end
      zprev = zbus.state_code;
   end

   // Scenario monitor: state sequence, timer starts with their loads/actuators, trips.
   bit mon_en = 0;
   int n_start, n_trip;
   int seq[$], secq[$], actq[$];
   logic [2:0] last_sc;
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.state_code != last_sc) seq.push_back(int'(bus.state_code));
         last_sc = bus.state_code;
         if (bus.timer_start) begin
            n_start++;
            secq.push_back(int'(bus.timer_seconds));
            actq.push_back(int'({bus.gate_lo_open, bus.gate_hi_open,
                                 bus.fill_valve, bus.drain_valve}));
         end
         if (bus.trip_done) n_trip++;
      end
   end

   task automatic clear_mon();
      mon_en = 1; n_start = 0; n_trip = 0;
      seq.delete(); secq.delete(); actq.delete();
      last_sc = bus.state_code;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pulse(input bit up, input bit dn, input bit zu, input bit zd);
      bus.req_up = up; bus.req_down = dn; zbus.req_up = zu; zbus.req_down = zd;
      step();
      bus.req_up = 0; bus.req_down = 0; zbus.req_up = 0; zbus.req_down = 0;
   endtask

   task automatic wait_state(input int sc, input int budget, input string nm);
      int n = 0;
      while (int'(bus.state_code) != sc && n < budget) begin step(); n++; end
      if (int'(bus.state_code) != sc) check({nm, "_timeout"}, int'(bus.state_code), sc);
   endtask

   task automatic wait_trips(input int k, input int budget, input string nm);
      int n = 0;
      while (n_trip < k && n < budget) begin step(); n++; end
      if (n_trip < k) check({nm, "_timeout"}, n_trip, k);
      step();
   endtask

   initial begin
      int e[$];
      reset = 0;
      bus.req_up = 0; bus.req_down = 0; zbus.req_up = 0; zbus.req_down = 0;

      // Reset to INIT
      repeat (3) step();
      check("rst_state",   int'(bus.state_code), 0);
      check("rst_seconds", int'(bus.timer_seconds), 7);
      check("rst_start",   int'(bus.timer_start), 0);
      check("rst_drain",   int'(bus.drain_valve), 0);
      check("rst_level",   int'(bus.level_high), 0);
      reset = 1;
      step();
      check("init_start",   int'(bus.timer_start), 1);
      check("init_seconds", int'(bus.timer_seconds), 7);
      check("init_drain",   int'(bus.drain_valve), 1);
      check("init_state",   int'(bus.state_code), 0);
      wait_state(1, 40, "init");
      check("init_level", int'(bus.level_high), 0);

      // Reposition: down request while low
      clear_mon();
      pulse(0, 1, 0, 1);
      wait_trips(1, 200, "repos");
      e = '{5, 1, 2, 3, 4, 1};       check_q("repos_seq", seq, e);
      e = '{7, 5, 7, 5};             check_q("repos_secs", secq, e);
      e = '{4'b0010, 4'b0100, 4'b0001, 4'b1000}; check_q("repos_act", actq, e);
      check("repos_trips", n_trip, 1);
      check("repos_level", int'(bus.level_high), 0);

      // Up trip from low
      clear_mon();
      pulse(1, 0, 1, 0);
      wait_trips(1, 200, "up");
      e = '{2, 3, 4, 1};                  check_q("up_seq", seq, e);
      e = '{5, 7, 5};                     check_q("up_secs", secq, e);
      e = '{4'b1000, 4'b0010, 4'b0100};   check_q("up_act", actq, e);
      check("up_starts", n_start, 3);
      check("up_trips", n_trip, 1);
      check("up_level", int'(bus.level_high), 1);

      // Plain down trip back to low
      clear_mon();
      pulse(0, 1, 0, 0);
      wait_trips(1, 200, "down");
      e = '{2, 3, 4, 1};  check_q("down_seq", seq, e);
      check("down_level", int'(bus.level_high), 0);

      // Simultaneous requests at low: up first, down next, no REPOS
      clear_mon();
      pulse(1, 1, 0, 0);
      wait_trips(2, 400, "both");
      e = '{2, 3, 4, 1, 2, 3, 4, 1};  check_q("both_seq", seq, e);
      check("both_starts", n_start, 6);
      check("both_level", int'(bus.level_high), 0);

      // Reset during MOVE with a down request latched
      pulse(1, 0, 0, 0);
      wait_state(3, 60, "mid_move");
      pulse(0, 1, 0, 0);
      reset = 0;
      step();
      check("mid_state", int'(bus.state_code), 0);
      check("mid_actuators", int'({bus.gate_lo_open, bus.gate_hi_open,
                                   bus.fill_valve, bus.drain_valve}), 0);
      check("mid_start", int'(bus.timer_start), 0);
      check("mid_level", int'(bus.level_high), 0);
      step();
      reset = 1;
      clear_mon();
      wait_state(1, 40, "mid_init");
      repeat (30) step();
      check("mid_idle_state", int'(bus.state_code), 1);
      check("mid_trips", n_trip, 0);
      check("mid_starts", n_start, 1);

      check("zero_timed_states", zcount, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
